// File: rtl/mem_bus_pkg.sv
// Shared definitions for the word-to-byte memory bus master.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int BEATS      = 4;
    localparam int BEAT_BITS  = 2;
    localparam int WORD_BYTES = 4;

    // Select byte lane k of a 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [BEAT_BITS-1:0] k);
        logic [7:0] lane;
        case (k)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            2'd3:    lane = word[31:24];
            default: lane = 8'h00;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/word_mem_master.sv
// Word request master: turns one 32-bit read/write request into four
// low-byte-first beats on the 8-bit memory bus, then pulses a response.
// Every bus output is a flop, so each beat's addr/writedata/memwrite are
// prepared on the edge that enters the beat.
module word_mem_master
    import mem_bus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_bmask,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             memwrite,
    output logic [WIDTH-1:0] addr,
    output logic [7:0]       writedata,
    input  logic [7:0]       memdata
);

    state_e                 state_r;
    logic [BEAT_BITS-1:0]   k_r;
    logic [WIDTH-1:0]       base_r;
    logic                   write_r;
    logic [31:0]            wdata_r;
    logic [3:0]             bmask_r;
    logic [23:0]            acc_r;
    logic                   req_ready_r;
    logic                   resp_valid_r;
    logic [31:0]            resp_rdata_r;
    logic                   memwrite_r;
    logic [WIDTH-1:0]       addr_r;
    logic [7:0]             writedata_r;

    logic                   accept_s;
    logic [BEAT_BITS-1:0]   k_nxt_s;
    logic [WIDTH-1:0]       req_base_s;

    assign accept_s   = req_valid & req_ready_r;
    assign k_nxt_s    = k_r + 2'd1;
    // Word base: the two byte-offset bits are forced to zero.
    assign req_base_s = req_addr & {{(WIDTH-2){1'b1}}, 2'b00};

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign memwrite   = memwrite_r;
    assign addr       = addr_r;
    assign writedata  = writedata_r;

    // Request FSM, beat sequencing, read-byte assembly and registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            k_r          <= 2'd0;
            base_r       <= {WIDTH{1'b0}};
            write_r      <= 1'b0;
            wdata_r      <= 32'h0000_0000;
            bmask_r      <= 4'h0;
            acc_r        <= 24'h00_0000;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            memwrite_r   <= 1'b0;
            addr_r       <= {WIDTH{1'b0}};
            writedata_r  <= 8'h00;
        end else begin
            // Bus is idle unless a beat below drives it.
            resp_valid_r <= 1'b0;
            memwrite_r   <= 1'b0;
            addr_r       <= {WIDTH{1'b0}};
            writedata_r  <= 8'h00;
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        state_r      <= XFER;
                        k_r          <= 2'd0;
                        base_r       <= req_base_s;
                        write_r      <= req_write;
                        wdata_r      <= req_wdata;
                        bmask_r      <= req_bmask;
                        acc_r        <= 24'h00_0000;
                        req_ready_r  <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                        // Beat 0 is presented in the very next cycle.
                        addr_r       <= req_base_s;
                        memwrite_r   <= req_write & req_bmask[0];
                        writedata_r  <= req_write ? byte_lane(req_wdata, 2'd0) : 8'h00;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                XFER: begin
                    if (!write_r) begin
                        case (k_r)
                            2'd0:    acc_r[7:0]   <= memdata;
                            2'd1:    acc_r[15:8]  <= memdata;
                            2'd2:    acc_r[23:16] <= memdata;
                            default: acc_r        <= acc_r;
                        endcase
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (k_r == 2'd3) begin
                        state_r      <= RESP;
                        req_ready_r  <= 1'b1;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= write_r ? 32'h0000_0000 : {memdata, acc_r};
                    end else begin
                        k_r         <= k_nxt_s;
                        addr_r      <= base_r | {{(WIDTH-2){1'b0}}, k_nxt_s};
                        memwrite_r  <= write_r & bmask_r[k_nxt_s];
                        writedata_r <= write_r ? byte_lane(wdata_r, k_nxt_s) : 8'h00;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    k_r         <= 2'd0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_mem_master.sv
// Self-checking bench for word_mem_master with a byte-wide memory and a
// word-level reference model.
module tb_word_mem_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_bmask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        memwrite;
    logic [7:0]  addr;
    logic [7:0]  writedata;
    logic [7:0]  memdata;

    // Byte memory attached to the bus, plus a preload port used during reset.
    logic [7:0]  mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [7:0]  pl_d;

    // Word-level reference model of memory contents.
    logic [31:0] ref_mem [0:63];

    int checks;
    int failures;
    int cyc;
    int last_resp_cyc;
    bit prev_chain;
    logic [31:0] got;

    word_mem_master #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_bmask  (req_bmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .memdata    (memdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memdata = mem[addr];

    // Memory write port: preload, else commit on a memwrite edge.
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (memwrite) mem[addr] <= writedata;
    end

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One word request. Starts mid-cycle with the DUT ready; returns in the
    // RESP cycle when chain=1, otherwise one cycle later.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit chain, output logic [31:0] rd);
        logic [7:0]  base;
        logic [31:0] exp_r;
        base  = {a[7:2], 2'b00};
        exp_r = w ? 32'h0 : ref_mem[a[7:2]];
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_bmask = m;
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble request inputs: the latched copy must be used.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        req_bmask = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
            chk("beat_addr", {24'd0, addr}, {24'd0, base + 8'(k)});
            chk("beat_memwrite", {31'd0, memwrite}, {31'd0, w & m[k]});
            chk("beat_writedata", {24'd0, writedata}, w ? {24'd0, d[8*k +: 8]} : 32'd0);
            chk("beat_req_ready", {31'd0, req_ready}, 32'd0);
            chk("beat_resp_valid", {31'd0, resp_valid}, 32'd0);
            if (k == 0) chk("rdata_cleared", resp_rdata, 32'd0);
            @(posedge clk); #1;
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_r);
        chk("resp_req_ready", {31'd0, req_ready}, 32'd1);
        chk("resp_bus_idle", {23'd0, memwrite, addr}, 32'd0);
        if (prev_chain) chk("b2b_spacing", 32'(cyc - last_resp_cyc), 32'd5);
        last_resp_cyc = cyc;
        rd = resp_rdata;
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (m[k]) ref_mem[a[7:2]][8*k +: 8] = d[8*k +: 8];
        end
        prev_chain = chain;
        if (!chain) begin
            @(posedge clk); #1;
            chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
            chk("rdata_hold", resp_rdata, exp_r);
            chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] b;
        checks = 0; failures = 0; cyc = 0; last_resp_cyc = 0; prev_chain = 1'b0;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
        req_wdata = 32'h0; req_bmask = 4'h0; pl_en = 1'b0; pl_a = 8'h00; pl_d = 8'h00;

        // Preload memory during reset; word 0x20 starts at zero.
        @(posedge clk); #1;
        pl_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b = (i >= 32 && i < 36) ? 8'h00 : 8'($urandom);
            pl_a = 8'(i);
            pl_d = b;
            ref_mem[i / 4][8 * (i % 4) +: 8] = b;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        // Reset state.
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_bus", {15'd0, memwrite, addr, writedata}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full write, misaligned read, masked write and read-back.
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, got);
        xfer(1'b0, 8'h13, 32'h0, 4'h0, 1'b0, got);
        chk("plan_read_deadbeef", got, 32'hDEADBEEF);
        xfer(1'b1, 8'h10, 32'h11223344, 4'b0101, 1'b0, got);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, got);
        chk("plan_masked_readback", got, 32'hDE22BE44);

        // Back-to-back: write then read of 0x10 accepted in RESP.
        xfer(1'b1, 8'h10, $urandom, 4'($urandom), 1'b1, got);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, got);

        // Reset during beat 2 of a write to 0x20.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20;
        req_wdata = 32'hAABBCCDD; req_bmask = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_beat2_addr", {24'd0, addr}, 32'h22);
        chk("abort_beat2_memwrite", {31'd0, memwrite}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_bus_cleared", {15'd0, memwrite, addr, writedata}, 32'd0);
        chk("abort_resp", {31'd0, resp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        ref_mem[8][15:0] = 16'hCCDD;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        reset = 1'b1;
        prev_chain = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 8'h20, 32'h0, 4'h0, 1'b0, got);
        chk("abort_readback", got, 32'h0000CCDD);

        // Top of address space.
        xfer(1'b0, 8'hFE, 32'h0, 4'h0, 1'b0, got);

        // Randomized traffic with random chaining and idle gaps.
        for (int t = 0; t < 24; t++) begin
            bit ch;
            ch = (t < 23) ? 1'($urandom) : 1'b0;
            xfer(1'($urandom), 8'($urandom), $urandom, 4'($urandom), ch, got);
            if (!ch) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_mem_master.md
Name: word_mem_master

Overview:
- Initiator side of the byte-wide memory interface (memwrite/addr/writedata/memdata) served by the byte-addressed external memory.
- Accepts one 32-bit word read or write request on a valid/ready port.
- Performs it as four sequential byte beats, low byte first, then returns a one-cycle response.
- Sits between any 32-bit client (DMA, loader, debug port) and the 8-bit memory bus in place of the core.

Parameters:
WIDTH, 8, byte-address width of the memory bus; the word base is addr[WIDTH-1:2].

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present
req_ready  output  1  request accepted on a cycle where req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  WIDTH  byte address; bits [1:0] ignored
req_wdata  input  32  write word; byte k = bits [8k+7:8k]
req_bmask  input  4  write byte enables, bit k covers byte k; ignored on reads
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  read word; 0 after a write
memwrite  output  1  byte write strobe to memory
addr  output  WIDTH  byte address to memory
writedata  output  8  write byte to memory
memdata  input  8  read byte from memory, combinational from addr

Behaviour:
- Memory timing: memdata is valid in the same cycle addr is driven. A write commits at the posedge where memwrite=1.
- States:
  - IDLE: req_ready=1.
  - XFER: beat counter k = 0..3, req_ready=0.
  - RESP: resp_valid=1, req_ready=1.
- Transitions:
  - IDLE --accept--> XFER, k=0.
  - XFER with k<3 -> XFER, k+1.
  - XFER with k=3 -> RESP.
  - RESP --accept--> XFER, k=0.
  - RESP with no request -> IDLE.
- On accept, latch base = {req_addr[WIDTH-1:2],2'b00}, req_write, req_wdata and req_bmask. Later changes on req_* have no effect.
- XFER beat k:
  - addr = base + k; carry never crosses the word, no wrap.
  - Write: writedata = latched byte k; memwrite = bmask[k].
  - Read: memwrite=0, writedata=0; capture memdata into rdata[8k+7:8k] at the end of the beat.
- Fixed latency: accept at edge E; beats occupy cycles E+1..E+4; resp_valid high in cycle E+5.
- Always 4 beats, even if bmask=0; resp_valid still pulses.
- Throughput: one word per 5 cycles with back-to-back requests accepted in RESP.
- resp_rdata:
  - Valid only while resp_valid=1.
  - Holds its value until the next accept, then clears to 0.
  - Is 0 for writes.
- Outside XFER: memwrite=0, addr=0, writedata=0.
- All outputs come from flops only; there is no combinational path from req_* or memdata to any output.
- Reset (reset=0), asynchronous and also mid-transfer:
  - state=IDLE, k=0, memwrite=0, addr=0, writedata=0, resp_valid=0, resp_rdata=0, req_ready=1.
  - An aborted transfer produces no response.
  - Bytes already committed stay in memory.
- memwrite never asserts for more than one cycle per byte address within a request.

Decomposition:
- Shared package (mem_bus_pkg): state encodings IDLE/XFER/RESP, BEATS=4, BEAT_BITS=2, WORD_BYTES=4.
- No sub-module. The byte-lane select and insert are small inline muxes indexed by k.

Test Plan:
- Full write: write 0xDEADBEEF to 0x10, bmask=4'hF.
  - Cycles E+1..E+4: addr 0x10,0x11,0x12,0x13; writedata EF,BE,AD,DE; memwrite=1.
  - resp_valid=1 at E+5 with resp_rdata=0.
- Misaligned read: read from req_addr=0x13.
  - addr sequence 0x10..0x13; resp_rdata=0xDEADBEEF at E+5.
- Masked write: write 0x11223344 to 0x10 with bmask=4'b0101.
  - memwrite is 1,0,1,0 across the beats.
  - Read back 0x10 -> 0xDE22BE44.
- Back-to-back: hold req_valid through RESP with a read of 0x10 following a write.
  - Second request accepted in the RESP cycle; resp_valid pulses exactly 5 cycles apart; no idle cycle between.
- Reset mid-write: word 0x20 initially 0; write 0xAABBCCDD.
  - Drive reset=0 asynchronously during beat 2, before its commit edge.
  - Outputs clear immediately; no resp_valid.
  - After reset=1, read 0x20 -> 0x0000CCDD.
- Top of space: read req_addr=0xFE with WIDTH=8.
  - addr 0xFC,0xFD,0xFE,0xFF, no wrap to 0x00.
  - resp_rdata equals preloaded mem word 63.
